// File: rtl/translator_out_if.sv
// translator_out_if: Avalon-ST source bundle carrying the unpacked beat from translator_out.
interface translator_out_if #(
    parameter int DATA_WIDTH = 512
);
    localparam int EW = $clog2(DATA_WIDTH / 8);

    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  sop;
    logic                  eop;
    logic                  error;
    logic [EW-1:0]         empty;

    modport master (output data, valid, sop, eop, error, empty, input ready);
    modport slave  (input data, valid, sop, eop, error, empty, output ready);
endinterface

// File: rtl/translator_out.sv
// translator_out: NoC word -> Avalon-ST beat unpacker (head/payload modes), 2-entry skid buffer, framing check.
// Define TRANSLATOR_OUT_STATS_EN to add o_pkt_count / o_err_count statistics outputs.
module translator_out #(
    parameter int DATA_WIDTH = 512,
    parameter int WIDTH_IN   = 600,
    parameter int NUM_VC     = 2,
    parameter int NOC_RADIX  = 16,
    localparam int VW        = $clog2(NUM_VC),
    localparam int AW        = $clog2(NOC_RADIX),
    localparam int EW        = $clog2(DATA_WIDTH / 8)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH_IN-1:0] i_data_in,
    input  logic                i_valid_in,
    output logic                i_ready_out,
    input  logic                i_payload_in,
    translator_out_if.master    out,
    output logic [31:0]         o_pktid_out,
    output logic [AW-1:0]       o_dst_out,
    output logic [VW-1:0]       o_vc_out,
    output logic                o_framing_err
`ifdef TRANSLATOR_OUT_STATS_EN
    ,
    output logic [31:0]         o_pkt_count,
    output logic [15:0]         o_err_count
`endif
);
    localparam int Q    = WIDTH_IN / 4;
    localparam int FD   = Q - 3 - VW - AW;
    localparam int CW   = DATA_WIDTH / 4;
    localparam int PW   = DATA_WIDTH + 34;
    localparam int TOPB = PW - 3 * FD;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  sop;
        logic                  eop;
        logic                  error;
        logic [EW-1:0]         empty;
        logic [31:0]           pktid;
        logic [AW-1:0]         dst;
        logic [VW-1:0]         vc;
    } beat_t;

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t        state, state_next;
    beat_t         dec;
    beat_t         mem [2];
    beat_t         head;
    logic [PW-1:0] pword;
    logic [1:0]    count, count_next;
    logic          wr_ptr, rd_ptr;
    logic          push, pop;
    logic          sop, eop;
    logic          frame_err, hdr_err, flagged;
    logic          unused_bits;

    // Pad bits and the routing fields of flits 0..2 carry nothing for this block.
    assign unused_bits = ^i_data_in;

    assign sop   = i_data_in[4*Q-2];
    assign eop   = i_data_in[Q-3];
    assign push  = i_valid_in && i_ready_out && i_data_in[4*Q-1];
    assign pop   = out.valid && out.ready;
    assign pword = {i_data_in[3*Q+FD-1 -: FD], i_data_in[2*Q+FD-1 -: FD],
                    i_data_in[Q+FD-1 -: FD],   i_data_in[FD-1 -: TOPB]};

    always_comb begin
        state_next = state;
        frame_err  = 1'b0;
        if (push) begin
            unique case (state)
                IDLE: begin
                    if (!sop)
                        frame_err = 1'b1;
                    else if (!eop)
                        state_next = IN_PKT;
                end
                IN_PKT: begin
                    frame_err = sop;
                    if (eop)
                        state_next = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        dec     = '0;
        hdr_err = 1'b0;
        dec.sop = sop;
        dec.eop = eop;
        dec.vc  = i_data_in[4*Q-4 -: VW];
        dec.dst = i_data_in[4*Q-4-VW -: AW];
        if (i_payload_in) begin
            dec.data  = pword[DATA_WIDTH-1:0];
            dec.pktid = pword[DATA_WIDTH+31 -: 32];
            hdr_err   = !(pword[PW-1] && !pword[PW-2]);
        end else begin
            dec.data  = {i_data_in[3*Q+FD-1 -: CW], i_data_in[2*Q+FD-1 -: CW],
                         i_data_in[Q+FD-1 -: CW],   i_data_in[FD-1 -: CW]};
            dec.error = i_data_in[3*Q+FD-1-CW];
            dec.empty = i_data_in[3*Q+FD-2-CW -: EW];
        end
        flagged   = frame_err || hdr_err;
        dec.error = dec.error || flagged;
    end

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 2'd1;
        else if (pop && !push)
            count_next = count - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            i_ready_out   <= 1'b1;
            o_framing_err <= 1'b0;
            for (int unsigned i = 0; i < 2; i++)
                mem[i] <= '0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            i_ready_out <= (count_next < 2'd2);
            if (push) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            if (push && flagged)
                o_framing_err <= 1'b1;
        end
    end

    assign head        = mem[rd_ptr];
    assign out.valid   = (count != 2'd0);
    assign out.data    = head.data;
    assign out.sop     = head.sop;
    assign out.eop     = head.eop;
    assign out.error   = head.error;
    assign out.empty   = head.empty;
    assign o_pktid_out = head.pktid;
    assign o_dst_out   = head.dst;
    assign o_vc_out    = head.vc;

`ifdef TRANSLATOR_OUT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_pkt_count <= '0;
            o_err_count <= '0;
        end else begin
            if (pop && head.eop)
                o_pkt_count <= o_pkt_count + 32'd1;
            if (push && flagged)
                o_err_count <= o_err_count + 16'd1;
        end
    end
`endif
endmodule
